canny_nms_threshold: RTL and testbench

- Downstream of the Sobel 3x3 window buffer. Consumes its 9-element window (each element is packed gx/gy/magnitude) and the matching valid.
- Performs non-maximum suppression along the quantised gradient direction, then classifies survivors against low/high thresholds.
- Output is a thinned magnitude stream with a 2-bit edge class, feeding the hysteresis/edge-tracking stage.
- 3-stage fixed pipeline with no stall. Also tracks output position and flags end of frame.

---
 rtl/canny_nms_threshold_if.sv | 28 ++
 rtl/canny_nms_threshold.sv | 141 ++++++++++++++
 tb/tb_canny_nms_threshold.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/canny_nms_threshold_if.sv
// Window-in / thinned-magnitude-out bus for the Canny NMS + threshold stage.
// Ports: din_valid, window_data_all, window_mid (window side);
//        dout, edge_class, dout_valid, frame_done (result side).
interface canny_nms_threshold_if #(
  parameter int DATAWID         = 40,
  parameter int WINDOW_DATA_WID = 360,
  parameter int MAGWID          = 16
);
  logic                       din_valid;
  logic [WINDOW_DATA_WID-1:0] window_data_all;
  logic [DATAWID-1:0]         window_mid;
  logic [MAGWID-1:0]          dout;
  logic [1:0]                 edge_class;
  logic                       dout_valid;
  logic                       frame_done;

  // master: window producer / result consumer (upstream buffer + downstream tracker)
  modport master (
    output din_valid, window_data_all, window_mid,
    input  dout, edge_class, dout_valid, frame_done
  );

  // slave: the NMS/threshold block itself
  modport slave (
    input  din_valid, window_data_all, window_mid,
    output dout, edge_class, dout_valid, frame_done
  );
endinterface

// File: rtl/canny_nms_threshold.sv
// Canny non-maximum suppression along the quantised gradient direction, then low/high threshold classification.
// Latency: fixed 3 cycles (window registered, sector + neighbour select, suppress + classify); one window per cycle.
// Backpressure: none; the pipeline advances every cycle and valid travels with the data.
// Ports: clk, rst (sync, active high); bus (slave: window in, dout/edge_class/dout_valid/frame_done out);
//        IW/IH (upstream image size, sets output frame of (IW-2)x(IH-2)); th_low/th_high (edge thresholds).
module canny_nms_threshold #(
  parameter int DATAWID         = 40,
  parameter int WINDOW_DATA_WID = 360,
  parameter int MAGWID          = 16
) (
  input  logic                clk,
  input  logic                rst,
  canny_nms_threshold_if.slave bus,
  input  logic [10:0]         IW,
  input  logic [10:0]         IH,
  input  logic [MAGWID-1:0]   th_low,
  input  logic [MAGWID-1:0]   th_high
);

  // ---------------- S1: register magnitudes, |gx|, |gy| and sign relation ----------------
  logic [11:0] gx_in, gy_in, ax_in, ay_in;
  assign gx_in = bus.window_mid[DATAWID-1 -: 12];
  assign gy_in = bus.window_mid[DATAWID-13 -: 12];
  // Two's-complement negate in 12 bits: -2048 comes out as 12'h800, i.e. 2048 unsigned.
  assign ax_in = gx_in[11] ? (~gx_in + 12'd1) : gx_in;
  assign ay_in = gy_in[11] ? (~gy_in + 12'd1) : gy_in;

  // gx/gy of the neighbours and the duplicate centre copy are not needed; only their magnitudes matter.
  logic [WINDOW_DATA_WID-1:0] unused_window_bits;
  assign unused_window_bits = bus.window_data_all;

  logic              v1;
  logic [MAGWID-1:0] mag1 [9];
  logic [11:0]       ax1, ay1;
  logic              sgn1;

  always_ff @(posedge clk) begin
    if (rst) v1 <= 1'b0;
    else     v1 <= bus.din_valid;
    for (int k = 0; k < 9; k++) begin
      if (k == 4) mag1[k] <= bus.window_mid[MAGWID-1:0];
      else        mag1[k] <= bus.window_data_all[DATAWID*k +: MAGWID];
    end
    ax1  <= ax_in;
    ay1  <= ay_in;
    sgn1 <= gx_in[11] ^ gy_in[11];
  end

  // ---------------- S2: direction sector and neighbour pick ----------------
  // ay/ax against tan(22.5)=106/256 and tan(67.5)=618/256, all in 22-bit unsigned.
  logic [21:0]       ay_s, ax_lo, ax_hi;
  logic [MAGWID-1:0] n_lo_c, n_hi_c;
  assign ay_s  = {2'b00, ay1, 8'b0};
  assign ax_lo = 22'(ax1) * 22'd106;
  assign ax_hi = 22'(ax1) * 22'd618;

  always_comb begin
    n_lo_c = mag1[3];
    n_hi_c = mag1[5];
    if (ay_s <= ax_lo) begin           // near-horizontal gradient (includes gx=gy=0)
      n_lo_c = mag1[3];
      n_hi_c = mag1[5];
    end else if (ay_s >= ax_hi) begin  // near-vertical gradient
      n_lo_c = mag1[1];
      n_hi_c = mag1[7];
    end else if (!sgn1) begin          // same signs: top-left / bottom-right diagonal
      n_lo_c = mag1[0];
      n_hi_c = mag1[8];
    end else begin                     // opposite signs: top-right / bottom-left diagonal
      n_lo_c = mag1[2];
      n_hi_c = mag1[6];
    end
  end

  logic              v2;
  logic [MAGWID-1:0] m2, lo2, hi2;

  always_ff @(posedge clk) begin
    if (rst) v2 <= 1'b0;
    else     v2 <= v1;
    m2  <= mag1[4];
    lo2 <= n_lo_c;
    hi2 <= n_hi_c;
  end

  // ---------------- S3: suppression, classification, position tracking ----------------
  // Strict compare on the higher-index side so a flat plateau keeps exactly one pixel.
  logic       keep;
  logic [1:0] class_c;
  assign keep = (m2 >= lo2) && (m2 > hi2);

  always_comb begin
    class_c = 2'd0;
    if (keep && (m2 >= th_high))     class_c = 2'd2;
    else if (keep && (m2 >= th_low)) class_c = 2'd1;
  end

  logic [10:0] out_col, out_row;
  logic        col_last, row_last;
  assign col_last = (out_col == IW - 11'd3);
  assign row_last = (out_row == IH - 11'd3);

  // Counters hold the position of the output being produced this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_col <= 11'd0;
      out_row <= 11'd0;
    end else if (v2) begin
      if (col_last) begin
        out_col <= 11'd0;
        out_row <= row_last ? 11'd0 : out_row + 11'd1;
      end else begin
        out_col <= out_col + 11'd1;
      end
    end
  end

  logic [MAGWID-1:0] dout_q;
  logic [1:0]        class_q;
  logic              valid_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q  <= '0;
      class_q <= 2'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= v2;
      dout_q  <= (v2 && keep) ? m2 : '0;
      class_q <= v2 ? class_c : 2'd0;
      done_q  <= v2 && col_last && row_last;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.edge_class = class_q;
  assign bus.dout_valid = valid_q;
  assign bus.frame_done = done_q;

endmodule

// File: tb/tb_canny_nms_threshold.sv
// Bench for canny_nms_threshold: directed windows plus randomized windows with gaps,
// scored against a reference model; a separate monitor pops expectations on each output.
module tb_canny_nms_threshold;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] IW = 11'd6;
  logic [10:0] IH = 11'd6;
  logic [15:0] th_low = 16'd20;
  logic [15:0] th_high = 16'd45;

  always #5 clk = ~clk;

  canny_nms_threshold_if bus ();

  canny_nms_threshold dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus.slave),
    .IW      (IW),
    .IH      (IH),
    .th_low  (th_low),
    .th_high (th_high)
  );

  typedef struct {
    int mag;
    int cls;
    int fd;
    int cyc;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_expected = 0;
  int   n_seen = 0;
  int   frm_cnt = 0;
  int   wgx[9], wgy[9], wmag[9];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: sector from tan(22.5)/tan(67.5) ratios, then NMS with the asymmetric tie rule.
  task automatic model(output exp_t e);
    int ax, ay, lo, hi, m, fsize;
    bit keep;
    ax = (wgx[4] < 0) ? -wgx[4] : wgx[4];
    ay = (wgy[4] < 0) ? -wgy[4] : wgy[4];
    if (ay * 256 <= ax * 106)                begin lo = 3; hi = 5; end
    else if (ay * 256 >= ax * 618)           begin lo = 1; hi = 7; end
    else if ((wgx[4] < 0) != (wgy[4] < 0))   begin lo = 2; hi = 6; end
    else                                     begin lo = 0; hi = 8; end
    m     = wmag[4];
    keep  = (m >= wmag[lo]) && (m > wmag[hi]);
    e.mag = keep ? m : 0;
    if (!keep)                  e.cls = 0;
    else if (m >= int'(th_high)) e.cls = 2;
    else if (m >= int'(th_low))  e.cls = 1;
    else                         e.cls = 0;
    fsize   = (int'(IW) - 2) * (int'(IH) - 2);
    e.fd    = (frm_cnt == fsize - 1) ? 1 : 0;
    frm_cnt = (frm_cnt + 1) % fsize;
    e.cyc   = cyc + 3;
  endtask

  task automatic clear_win();
    for (int k = 0; k < 9; k++) begin
      wgx[k] = 0; wgy[k] = 0; wmag[k] = 0;
    end
  endtask

  // Called at a negedge; presents one valid window for one cycle.
  task automatic send();
    logic [359:0] wd;
    exp_t e;
    for (int k = 0; k < 9; k++)
      wd[40*k +: 40] = {wgx[k][11:0], wgy[k][11:0], wmag[k][15:0]};
    bus.din_valid       = 1'b1;
    bus.window_data_all = wd;
    bus.window_mid      = wd[160 +: 40];
    model(e);
    sbq.push_back(e);
    n_expected++;
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.din_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && sbq.size() > 0; i++) @(negedge clk);
    check("drain queue empty", sbq.size(), 0);
    idle(1);
  endtask

  // Sync reset: everything in flight is lost, so pending expectations go with it.
  task automatic do_reset();
    rst           = 1'b1;
    bus.din_valid = 1'b0;
    n_expected   -= sbq.size();
    sbq.delete();
    frm_cnt = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: samples 2 time units after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (bus.dout_valid === 1'b1) begin
        n_seen++;
        if (sbq.size() == 0) begin
          check("unexpected dout_valid", 1, 0);
        end else begin
          e = sbq.pop_front();
          check("dout", int'(bus.dout), e.mag);
          check("edge_class", int'(bus.edge_class), e.cls);
          check("frame_done", int'(bus.frame_done), e.fd);
          check("latency cycle", cyc, e.cyc);
        end
      end else begin
        check("idle outputs zero",
              int'({bus.dout_valid, bus.dout, bus.edge_class, bus.frame_done}), 0);
      end
    end
  end

  // Neighbour set used for sector-boundary windows: only one sector's pair is low.
  task automatic boundary(input int gx, input int gy, input int low_lo, input int low_hi);
    clear_win();
    for (int k = 0; k < 9; k++) wmag[k] = 200;
    wmag[4] = 100; wmag[low_lo] = 10; wmag[low_hi] = 10;
    wgx[4] = gx; wgy[4] = gy;
    send();
  endtask

  initial begin
    bus.din_valid       = 1'b0;
    bus.window_data_all = '0;
    bus.window_mid      = '0;
    repeat (3) @(negedge clk);
    check("reset dout_valid", int'(bus.dout_valid), 0);
    check("reset dout", int'(bus.dout), 0);
    check("reset edge_class", int'(bus.edge_class), 0);
    check("reset frame_done", int'(bus.frame_done), 0);
    rst = 1'b0;
    idle(2);

    // Horizontal sector, strong edge.
    clear_win();
    wgx[4] = 100; wmag[4] = 50; wmag[3] = 40; wmag[5] = 30;
    send(); idle(5);

    // Vertical sector, tie on the higher neighbour then not.
    clear_win();
    wgy[4] = -300; wmag[4] = 80; wmag[1] = 80; wmag[7] = 80;
    send();
    wmag[7] = 79;
    send(); idle(2);

    // Diagonals.
    clear_win();
    wgx[4] = 100; wgy[4] = 100; wmag[4] = 60; wmag[0] = 10; wmag[8] = 10;
    wmag[3] = 90; wmag[5] = 90;
    send();
    clear_win();
    wgx[4] = 100; wgy[4] = -100; wmag[4] = 60; wmag[2] = 61;
    send();
    drain();

    // Threshold edges.
    th_low = 16'd30; th_high = 16'd31;
    clear_win(); wgx[4] = 100; wmag[4] = 30;
    send();
    wmag[4] = 29;
    send();
    th_low = 16'd30; th_high = 16'd31;
    drain();

    // m=0 with zero thresholds, gx=gy=0, extreme negative gx.
    th_low = 16'd0; th_high = 16'd0;
    clear_win(); send();
    clear_win(); wgx[4] = -2048; wmag[4] = 5; wmag[3] = 5; send();
    clear_win(); wgy[4] = -2048; wmag[4] = 7; send();
    drain();

    // Exact sector boundaries.
    th_low = 16'd20; th_high = 16'd45;
    boundary(256, 106, 3, 5);
    boundary(256, 107, 3, 5);
    boundary(256, 618, 1, 7);
    boundary(256, 617, 1, 7);
    boundary(-256, 300, 2, 6);
    boundary(-256, -300, 0, 8);
    drain();

    // Randomized windows with random gaps, two threshold settings.
    for (int blk = 0; blk < 2; blk++) begin
      th_low  = 16'($urandom_range(0, 40));
      th_high = th_low + 16'($urandom_range(0, 30));
      for (int i = 0; i < 150; i++) begin
        for (int k = 0; k < 9; k++) wmag[k] = $urandom_range(0, 63);
        if ($urandom_range(0, 3) == 0) begin
          wgx[4] = int'($urandom_range(0, 20)) - 10;
          wgy[4] = int'($urandom_range(0, 20)) - 10;
        end else begin
          wgx[4] = int'($urandom_range(0, 4095)) - 2048;
          wgy[4] = int'($urandom_range(0, 4095)) - 2048;
        end
        send();
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
      end
      drain();
    end

    // Frame sequencing from a clean start: back-to-back frame, then a gapped frame.
    do_reset();
    th_low = 16'd10; th_high = 16'd40;
    for (int i = 0; i < 16; i++) begin
      clear_win(); wgx[4] = 50; wmag[4] = $urandom_range(0, 60);
      send();
    end
    for (int i = 0; i < 16; i++) begin
      clear_win(); wgx[4] = 50; wmag[4] = $urandom_range(0, 60);
      send(); idle(1);
    end
    drain();

    // Mid-frame reset: two windows in flight are discarded, counters restart.
    clear_win(); wgx[4] = 50; wmag[4] = 33;
    send(); send();
    do_reset();
    idle(4);
    for (int i = 0; i < 16; i++) begin
      clear_win(); wgx[4] = 50; wmag[4] = $urandom_range(0, 60);
      send();
    end
    drain();

    check("output count", n_seen, n_expected);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
